// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pkg
//  Description : Frame geometry, depth type and dispatcher state encoding
//                shared by the line dispatcher, results buffer and colour LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int X_SIZE  = 640;
    localparam int Y_SIZE  = 480;
    localparam int DEPTH_W = 10;
    localparam int XW      = $clog2(X_SIZE);
    localparam int YW      = $clog2(Y_SIZE);

    typedef logic [DEPTH_W-1:0] depth_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } disp_state_e;

endpackage : mandel_pkg
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pick
//  Description : Lowest-set-bit selector. Reports whether any request bit is
//                set and the index of the lowest one.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule : prio_pick
`default_nettype wire

// File: rtl/line_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : line_dispatcher
//  Description : Hands every x-position of the current line to a pool of
//                iteration engines, gathers their escape depths and writes
//                each one to the line results buffer, then pulses done and
//                advances the line counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_dispatcher #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = mandel_pkg::X_SIZE,
    parameter int Y_SIZE      = mandel_pkg::Y_SIZE,
    parameter int DEPTH_W     = mandel_pkg::DEPTH_W,
    parameter int XW          = $clog2(X_SIZE),
    parameter int YW          = $clog2(Y_SIZE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*XW-1:0]      eng_x,
    output logic [YW-1:0]                  eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic [DEPTH_W-1:0]             depth_out,
    output logic [XW-1:0]                  addr_out,
    output logic                           we_out,
    output logic                           done,
    output logic                           busy
);

    import mandel_pkg::*;

    localparam int            EW         = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [XW:0]   C_X_END    = (XW+1)'(X_SIZE);
    localparam logic [YW-1:0] C_Y_LAST   = YW'(Y_SIZE - 1);

    disp_state_e               state_q,     state_d;
    logic [XW:0]               next_x_q,    next_x_d;
    logic [XW:0]               written_q,   written_d;
    logic [YW-1:0]             eng_y_q,     eng_y_d;
    logic [NUM_ENGINES-1:0]    busy_vec_q,  busy_vec_d;
    logic [NUM_ENGINES-1:0]    pend_q,      pend_d;
    logic [NUM_ENGINES-1:0]    eng_start_q, eng_start_d;
    logic [XW-1:0]             eng_x_q      [NUM_ENGINES];
    logic [XW-1:0]             eng_x_d      [NUM_ENGINES];
    logic [DEPTH_W-1:0]        cap_q        [NUM_ENGINES];
    logic [DEPTH_W-1:0]        cap_d        [NUM_ENGINES];
    logic [DEPTH_W-1:0]        depth_out_q, depth_out_d;
    logic [XW-1:0]             addr_out_q,  addr_out_d;
    logic                      we_out_q,    we_out_d;
    logic [EW-1:0]             wr_idx_q,    wr_idx_d;

    logic [DEPTH_W-1:0]        w_eng_depth  [NUM_ENGINES];
    logic                      w_disp_valid;
    logic [EW-1:0]             w_disp_idx;
    logic                      w_wr_valid;
    logic [EW-1:0]             w_wr_idx;

    // Per-engine unpacking of the flat depth bus and packing of the x bus
    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        assign w_eng_depth[g]          = eng_depth[g*DEPTH_W +: DEPTH_W];
        assign eng_x[g*XW +: XW]       = eng_x_q[g];
    end

    prio_pick #(.N(NUM_ENGINES), .IW(EW)) u_disp_pick (
        .i_req   (~busy_vec_q),
        .o_valid (w_disp_valid),
        .o_idx   (w_disp_idx)
    );

    prio_pick #(.N(NUM_ENGINES), .IW(EW)) u_wr_pick (
        .i_req   (pend_q),
        .o_valid (w_wr_valid),
        .o_idx   (w_wr_idx)
    );

    // Next-state: line sequencing, engine capture, dispatch and write arbitration
    always_comb begin
        state_d     = state_q;
        next_x_d    = next_x_q;
        written_d   = written_q;
        eng_y_d     = eng_y_q;
        busy_vec_d  = busy_vec_q;
        pend_d      = pend_q;
        eng_start_d = '0;
        eng_x_d     = eng_x_q;
        cap_d       = cap_q;
        depth_out_d = depth_out_q;
        addr_out_d  = addr_out_q;
        we_out_d    = 1'b0;
        wr_idx_d    = wr_idx_q;

        // A completion is only meaningful from an engine we actually started
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (eng_done[i] && busy_vec_q[i]) begin
                pend_d[i] = 1'b1;
                cap_d[i]  = w_eng_depth[i];
            end
        end

        // Release the engine one cycle after its write is on the bus, so it
        // is re-dispatched no sooner than two cycles after that write
        if (we_out_q) begin
            busy_vec_d[wr_idx_q] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    next_x_d  = '0;
                    written_d = '0;
                end
            end
            RUN: begin
                if (written_q == C_X_END) begin
                    state_d = FINISH;
                end
                if (w_disp_valid && (next_x_q < C_X_END)) begin
                    eng_start_d[w_disp_idx] = 1'b1;
                    eng_x_d[w_disp_idx]     = next_x_q[XW-1:0];
                    busy_vec_d[w_disp_idx]  = 1'b1;
                    next_x_d                = next_x_q + 1'b1;
                end
                // Pending is dropped at issue so the same result is never
                // picked twice while its write is still in flight
                if (w_wr_valid) begin
                    we_out_d         = 1'b1;
                    depth_out_d      = cap_q[w_wr_idx];
                    addr_out_d       = eng_x_q[w_wr_idx];
                    wr_idx_d         = w_wr_idx;
                    pend_d[w_wr_idx] = 1'b0;
                    written_d        = written_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                eng_y_d = (eng_y_q == C_Y_LAST) ? '0 : eng_y_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            next_x_q    <= '0;
            written_q   <= '0;
            eng_y_q     <= '0;
            busy_vec_q  <= '0;
            pend_q      <= '0;
            eng_start_q <= '0;
            eng_x_q     <= '{default: '0};
            cap_q       <= '{default: '0};
            depth_out_q <= '0;
            addr_out_q  <= '0;
            we_out_q    <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            next_x_q    <= next_x_d;
            written_q   <= written_d;
            eng_y_q     <= eng_y_d;
            busy_vec_q  <= busy_vec_d;
            pend_q      <= pend_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            cap_q       <= cap_d;
            depth_out_q <= depth_out_d;
            addr_out_q  <= addr_out_d;
            we_out_q    <= we_out_d;
            wr_idx_q    <= wr_idx_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_y     = eng_y_q;
    assign depth_out = depth_out_q;
    assign addr_out  = addr_out_q;
    assign we_out    = we_out_q;
    assign done      = (state_q == FINISH);
    assign busy      = (state_q == RUN);

endmodule : line_dispatcher
`default_nettype wire

// File: tb/tb_line_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_line_dispatcher
//  Description : Self-checking bench for line_dispatcher with behavioural
//                iteration engines and a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_dispatcher;
    import mandel_pkg::*;

    localparam int NE    = 4;
    localparam int XR    = 1 << XW;
    localparam int LIMIT = 20000;

    // small instance used for the frame wrap
    localparam int X2  = 4;
    localparam int Y2  = 6;
    localparam int XW2 = 2;
    localparam int YW2 = 3;
    localparam int NE2 = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [NE-1:0]           eng_start;
    logic [NE*XW-1:0]        eng_x;
    logic [YW-1:0]           eng_y;
    logic [NE-1:0]           eng_done = '0;
    logic [NE*DEPTH_W-1:0]   eng_depth = '0;
    logic [DEPTH_W-1:0]      depth_out;
    logic [XW-1:0]           addr_out;
    logic                    we_out, done, busy;

    logic                    reset2 = 1'b1;
    logic                    start2 = 1'b0;
    logic [NE2-1:0]          eng_start2;
    logic [NE2*XW2-1:0]      eng_x2;
    logic [YW2-1:0]          eng_y2;
    logic [NE2-1:0]          eng_done2 = '0;
    logic [NE2*DEPTH_W-1:0]  eng_depth2 = '0;
    logic [DEPTH_W-1:0]      depth_out2;
    logic [XW2-1:0]          addr_out2;
    logic                    we_out2, done2, busy2;

    line_dispatcher #(.NUM_ENGINES(NE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_depth(eng_depth),
        .depth_out(depth_out), .addr_out(addr_out), .we_out(we_out),
        .done(done), .busy(busy)
    );

    line_dispatcher #(.NUM_ENGINES(NE2), .X_SIZE(X2), .Y_SIZE(Y2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2),
        .eng_start(eng_start2), .eng_x(eng_x2), .eng_y(eng_y2),
        .eng_done(eng_done2), .eng_depth(eng_depth2),
        .depth_out(depth_out2), .addr_out(addr_out2), .we_out(we_out2),
        .done(done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference engine behaviour: the depth an engine returns for pixel x of line ln
    function automatic int ref_depth(input int x, input int ln);
        return (x * 37 + ln * 101 + 5) % 1024;
    endfunction

    function automatic int lat_of(input int m, input int x);
        case (m)
            0:       return 5;
            1:       return (x % 7) + 1;
            2:       return (x < 4) ? 8 - x : 5;
            default: return int'($urandom_range(1, 12));
        endcase
    endfunction

    typedef struct {
        int x;
        int depth;
        int eng;
        int dcyc;
    } sb_t;

    sb_t sb[$];
    int  mode = 0;
    int  line = 0;
    int  exp_x = 0;
    bit  eact [NE];
    bit  ebusy[NE];
    int  ex   [NE];
    int  ecnt [NE];
    int  first_start[NE];
    int  last_wr    [NE];
    bit  disp_seen[XR];
    bit  wr_seen  [XR];
    int  wrcyc    [XR];
    int  doncyc   [XR];
    int  wcount = 0;
    int  last_we = -10;
    int  lines_done = 0;
    bit  chk_after = 1'b0;

    // Behavioural iteration engines: run for a latency, then return a depth
    always @(negedge clk) begin : eng_model
        int xv;
        eng_done = '0;
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                eact[i]  = 1'b0;
                ebusy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (eact[i]) begin
                    ecnt[i]--;
                    if (ecnt[i] == 0) begin
                        eact[i] = 1'b0;
                        eng_done[i] = 1'b1;
                        eng_depth[i*DEPTH_W +: DEPTH_W] = DEPTH_W'(ref_depth(ex[i], line));
                        sb.push_back('{x: ex[i], depth: ref_depth(ex[i], line), eng: i, dcyc: cyc});
                        doncyc[ex[i]] = cyc;
                    end
                end
            end
            if (eng_start != '0) begin
                chk("one_dispatch_per_cycle", 64'($countones(eng_start)), 1);
            end
            for (int i = 0; i < NE; i++) begin
                if (eng_start[i]) begin
                    xv = int'(eng_x[i*XW +: XW]);
                    chk("dispatch_x_order", xv, exp_x);
                    exp_x++;
                    chk("dispatch_x_dup", disp_seen[xv], 0);
                    disp_seen[xv] = 1'b1;
                    chk("dispatch_to_busy_engine", ebusy[i], 0);
                    if (last_wr[i] >= 0) begin
                        chk("redispatch_gap_ge2", (cyc - last_wr[i]) >= 2, 1);
                    end
                    if (first_start[i] < 0) first_start[i] = cyc;
                    eact[i]  = 1'b1;
                    ebusy[i] = 1'b1;
                    ex[i]    = xv;
                    ecnt[i]  = lat_of(mode, xv);
                end
            end
        end
    end

    // Monitor: match every write to an outstanding result, police done/busy/eng_y
    always @(negedge clk) begin : monitor
        int j;
        int e;
        if (reset) begin
            sb.delete();
            wcount    = 0;
            line      = 0;
            chk_after = 1'b0;
        end else begin
            if (chk_after) begin
                chk("busy_after_done", busy, 0);
                chk("eng_y_after_done", eng_y, line % Y_SIZE);
                chk_after = 1'b0;
            end
            if (we_out) begin
                chk("we_out_only_in_run", busy, 1);
                j = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].x == int'(addr_out)) begin
                        j = k;
                        break;
                    end
                end
                chk("write_addr_outstanding", (j >= 0), 1);
                if (j >= 0) begin
                    e = sb[j].eng;
                    chk("write_depth", depth_out, sb[j].depth);
                    if (mode == 0) chk("write_latency_exact", cyc - sb[j].dcyc, 2);
                    else           chk("write_latency_min", (cyc - sb[j].dcyc) >= 2, 1);
                    ebusy[e]   = 1'b0;
                    last_wr[e] = cyc;
                    sb.delete(j);
                end
                chk("write_addr_dup", wr_seen[addr_out], 0);
                wr_seen[addr_out] = 1'b1;
                wrcyc[addr_out]   = cyc;
                wcount++;
                last_we = cyc;
            end
            if (done) begin
                chk("done_write_count", wcount, X_SIZE);
                chk("done_after_last_we", cyc - last_we, 1);
                chk("busy_low_at_done", busy, 0);
                chk("eng_y_during_line", eng_y, line % Y_SIZE);
                wcount = 0;
                line++;
                lines_done++;
                chk_after = 1'b1;
            end
        end
    end

    // Small-instance engines answer in the cycle they are started
    int w2 = 0;
    int y2_exp = 0;
    int lines2 = 0;
    bit [X2-1:0] seen2 = '0;
    always @(negedge clk) begin : eng2_model
        eng_done2 = eng_start2;
        for (int i = 0; i < NE2; i++) begin
            eng_depth2[i*DEPTH_W +: DEPTH_W] = DEPTH_W'(eng_x2[i*XW2 +: XW2]) + DEPTH_W'(1);
        end
    end

    always @(negedge clk) begin : monitor2
        if (!reset2) begin
            if (we_out2) begin
                chk("wrap_depth", depth_out2, 64'(addr_out2) + 1);
                chk("wrap_addr_dup", seen2[addr_out2], 0);
                seen2[addr_out2] = 1'b1;
                w2++;
            end
            if (done2) begin
                chk("wrap_write_count", w2, X2);
                chk("wrap_eng_y", eng_y2, y2_exp);
                y2_exp = (y2_exp + 1) % Y2;
                w2     = 0;
                seen2  = '0;
                lines2++;
            end
        end
    end

    task automatic prep(input int m);
        mode  = m;
        exp_x = 0;
        for (int i = 0; i < NE; i++) begin
            first_start[i] = -1;
            last_wr[i]     = -1;
        end
        for (int x = 0; x < XR; x++) begin
            disp_seen[x] = 1'b0;
            wr_seen[x]   = 1'b0;
            wrcyc[x]     = -1;
            doncyc[x]    = -1;
        end
    endtask

    task automatic run_line(input int m, input int extra_at, output int t0);
        int  n0;
        bit  ok;
        prep(m);
        @(posedge clk); #1;
        start = 1'b1;
        t0    = cyc;
        n0    = lines_done;
        ok    = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge clk); #1;
            start = (extra_at > 0) && (cyc == t0 + extra_at);
            if (lines_done != n0) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("line_completes_in_budget", ok, 1);
        for (int i = 0; i < NE; i++) begin
            chk("first_dispatch_cycle", first_start[i], t0 + 2 + i);
        end
        for (int x = 0; x < X_SIZE; x++) begin
            if (!wr_seen[x]) begin
                chk("every_addr_written", x, -1);
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin : main
        int t0;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;
        @(negedge clk);
        chk("reset_eng_start", eng_start, 0);
        chk("reset_eng_x", eng_x, 0);
        chk("reset_eng_y", eng_y, 0);
        chk("reset_depth_out", depth_out, 0);
        chk("reset_addr_out", addr_out, 0);
        chk("reset_we_out", we_out, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);

        // fixed latency line
        run_line(0, 0, t0);
        chk("eng_y_after_first_line", eng_y, 1);

        // variable latency line
        run_line(1, 0, t0);

        // simultaneous completion of the first batch
        run_line(2, 0, t0);
        chk("simul_done_cycle0", doncyc[0], t0 + 10);
        for (int k = 1; k < NE; k++) begin
            chk("simul_done_same_cycle", doncyc[k], t0 + 10);
        end
        for (int k = 0; k < NE; k++) begin
            chk("simul_write_order", wrcyc[k], t0 + 12 + k);
        end

        // second start 50 cycles into a line
        run_line(3, 50, t0);

        // reset after 100 writes
        prep(3);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            if (wcount >= 100) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midline_reach_100_writes", ok, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_eng_start", eng_start, 0);
        chk("midreset_eng_x", eng_x, 0);
        chk("midreset_eng_y", eng_y, 0);
        chk("midreset_depth_out", depth_out, 0);
        chk("midreset_addr_out", addr_out, 0);
        chk("midreset_we_out", we_out, 0);
        chk("midreset_done", done, 0);
        chk("midreset_busy", busy, 0);
        repeat (20) @(negedge clk);
        run_line(0, 0, t0);
        chk("eng_y_after_reset_line", eng_y, 1);

        // frame wrap on the small instance
        for (int ln = 0; ln <= Y2; ln++) begin
            int n2;
            @(posedge clk); #1;
            start2 = 1'b1;
            n2 = lines2;
            @(posedge clk); #1;
            start2 = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (lines2 != n2) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("wrap_line_completes", ok, 1);
        end
        @(negedge clk);
        chk("wrap_final_eng_y", eng_y2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_line_dispatcher
`default_nettype wire
